mac_reg_bank: RTL and testbench

- Parametrised successor to the MAC CPU register block: a generic bank of NUM_REGS host registers, each with its own reset value and access type (RW, RO, self-clearing pulse, write-1-to-clear sticky).
- Adds an integrated RMON read sequencer that runs the CPU_rd_apply/CPU_rd_grant handshake, snapshots the 32-bit counter atomically and enforces a grant timeout.
- Sits between the 16-bit host bus (CSB/WRB/CA/CD) and the MAC TX/RX/PHY/RMON configuration inputs.

---
 rtl/mac_reg_pkg.sv | 24 ++
 rtl/mac_rmon_rd_seq.sv | 79 +++++++
 rtl/mac_reg_bank.sv | 132 +++++++++++++
 tb/tb_mac_reg_bank.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_reg_pkg.sv
// Shared constants and types for the MAC host register bank and its RMON read sequencer.
package mac_reg_pkg;

  localparam logic [1:0] RT_RW  = 2'd0;
  localparam logic [1:0] RT_RO  = 2'd1;
  localparam logic [1:0] RT_SC  = 2'd2;
  localparam logic [1:0] RT_W1C = 2'd3;

  localparam int unsigned RMON_CTRL = 0;
  localparam int unsigned RMON_STAT = 1;
  localparam int unsigned RMON_DL   = 2;
  localparam int unsigned RMON_DH   = 3;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_TOUT = 2;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRel
  } rmon_state_e;

endpackage

// File: rtl/mac_rmon_rd_seq.sv
// RMON counter read sequencer: runs the apply/grant handshake, snapshots the 32-bit
// counter on grant and gives up after RMON_TIMEOUT request cycles.
module mac_rmon_rd_seq
  import mac_reg_pkg::*;
#(
  parameter int unsigned RMON_AW      = 6,
  parameter int unsigned RMON_TIMEOUT = 255
) (
  input  logic               Clk_reg,
  input  logic               Reset,
  input  logic               i_start,
  input  logic [RMON_AW-1:0] i_addr,
  output logic               o_busy,
  output logic               o_done_set,
  output logic               o_tout_set,
  output logic [31:0]        o_snapshot,
  output logic [RMON_AW-1:0] CPU_rd_addr,
  output logic               CPU_rd_apply,
  input  logic               CPU_rd_grant,
  input  logic [31:0]        CPU_rd_dout
);

  localparam int unsigned CntW = $clog2(RMON_TIMEOUT + 1);

  rmon_state_e       r_state;
  rmon_state_e       w_state_next;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_inc;
  logic              w_timeout;
  logic              w_in_req;
  logic [RMON_AW-1:0] r_addr;
  logic [31:0]       r_snap;

  assign w_in_req  = (r_state == StReq);
  assign w_cnt_inc = r_cnt + CntW'(1);
  // Timeout fires on the RMON_TIMEOUT-th request cycle.
  assign w_timeout = (w_cnt_inc == CntW'(RMON_TIMEOUT));

  always_ff @(posedge Clk_reg or posedge Reset) begin
    if (Reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_next = StReq;
      StReq:   if (CPU_rd_grant || w_timeout) w_state_next = StRel;
      StRel:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    CPU_rd_apply = w_in_req;
    o_busy       = (r_state != StIdle);
    o_done_set   = w_in_req && CPU_rd_grant;
    o_tout_set   = w_in_req && !CPU_rd_grant && w_timeout;
  end

  always_ff @(posedge Clk_reg or posedge Reset) begin
    if (Reset) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_snap <= '0;
    end else begin
      r_cnt <= w_in_req ? w_cnt_inc : '0;
      if (i_start && (r_state == StIdle)) r_addr <= i_addr;
      if (w_in_req && CPU_rd_grant) r_snap <= CPU_rd_dout;
    end
  end

  assign CPU_rd_addr = r_addr;
  assign o_snapshot  = r_snap;

endmodule

// File: rtl/mac_reg_bank.sv
// Generic MAC host register bank (RW/RO/SC/W1C slices) with an RMON read window on the
// 16-bit host bus. Writes commit once per access; reads return data one cycle later.
module mac_reg_bank
  import mac_reg_pkg::*;
#(
  parameter int unsigned                NUM_REGS     = 48,
  parameter int unsigned                DATA_W       = 16,
  parameter int unsigned                ADDR_W       = 8,
  parameter logic [NUM_REGS*DATA_W-1:0] REG_INIT     = '0,
  parameter logic [NUM_REGS*2-1:0]      REG_TYPE     = '0,
  parameter int unsigned                RMON_BASE    = 60,
  parameter int unsigned                RMON_AW      = 6,
  parameter int unsigned                RMON_TIMEOUT = 255
) (
  input  logic                       Clk_reg,
  input  logic                       Reset,
  input  logic                       CSB,
  input  logic                       WRB,
  input  logic [ADDR_W-1:0]          CA,
  input  logic [DATA_W-1:0]          CD_in,
  output logic [DATA_W-1:0]          CD_out,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  input  logic [NUM_REGS*DATA_W-1:0] hw_in,
  input  logic [NUM_REGS*DATA_W-1:0] hw_set,
  output logic [RMON_AW-1:0]         CPU_rd_addr,
  output logic                       CPU_rd_apply,
  input  logic                       CPU_rd_grant,
  input  logic [31:0]                CPU_rd_dout,
  output logic                       rmon_irq
);

  localparam int unsigned IdxW = ADDR_W - 1;

  logic              r_wr_lvl;
  logic              w_wr_lvl;
  logic              w_wr_pulse;
  logic [IdxW-1:0]   w_idx;
  logic [DATA_W-1:0] w_slice_rd [NUM_REGS];
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] r_cd_out;
  logic              w_ctrl_hit;
  logic              w_stat_hit;
  logic              w_busy;
  logic              w_done_set;
  logic              w_tout_set;
  logic [31:0]       w_snap;
  logic              r_done;
  logic              r_tout;

  assign w_wr_lvl   = !CSB && !WRB;
  assign w_wr_pulse = w_wr_lvl && !r_wr_lvl;
  assign w_idx      = CA[ADDR_W-1:1];
  assign w_ctrl_hit = w_wr_pulse && (w_idx == IdxW'(RMON_BASE + RMON_CTRL));
  assign w_stat_hit = w_wr_pulse && (w_idx == IdxW'(RMON_BASE + RMON_STAT));

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    localparam logic [1:0]        Type = REG_TYPE[g*2 +: 2];
    localparam logic [DATA_W-1:0] Init = REG_INIT[g*DATA_W +: DATA_W];
    logic              w_hit;
    logic [DATA_W-1:0] r_val;

    assign w_hit = w_wr_pulse && (w_idx == IdxW'(g));

    always_ff @(posedge Clk_reg or posedge Reset) begin
      if (Reset) begin
        r_val <= Init;
      end else begin
        case (Type)
          RT_RW:   if (w_hit) r_val <= CD_in;
          RT_SC:   r_val <= w_hit ? CD_in : Init;
          // Set pulses are OR-ed in last so they win over a same-cycle clear.
          RT_W1C:  r_val <= (w_hit ? (r_val & ~CD_in) : r_val) | hw_set[g*DATA_W +: DATA_W];
          default: r_val <= r_val;
        endcase
      end
    end

    assign reg_out[g*DATA_W +: DATA_W] = r_val;
    assign w_slice_rd[g] = (Type == RT_RO) ? hw_in[g*DATA_W +: DATA_W] : r_val;
  end

  mac_rmon_rd_seq #(
    .RMON_AW      (RMON_AW),
    .RMON_TIMEOUT (RMON_TIMEOUT)
  ) u_rmon_rd_seq (
    .Clk_reg      (Clk_reg),
    .Reset        (Reset),
    .i_start      (w_ctrl_hit),
    .i_addr       (CD_in[RMON_AW-1:0]),
    .o_busy       (w_busy),
    .o_done_set   (w_done_set),
    .o_tout_set   (w_tout_set),
    .o_snapshot   (w_snap),
    .CPU_rd_addr  (CPU_rd_addr),
    .CPU_rd_apply (CPU_rd_apply),
    .CPU_rd_grant (CPU_rd_grant),
    .CPU_rd_dout  (CPU_rd_dout)
  );

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == IdxW'(i)) w_rd_data = w_slice_rd[i];
    end
    if (w_idx == IdxW'(RMON_BASE + RMON_CTRL)) w_rd_data = DATA_W'(CPU_rd_addr);
    if (w_idx == IdxW'(RMON_BASE + RMON_STAT)) begin
      w_rd_data[STAT_BUSY] = w_busy;
      w_rd_data[STAT_DONE] = r_done;
      w_rd_data[STAT_TOUT] = r_tout;
    end
    if (w_idx == IdxW'(RMON_BASE + RMON_DL)) w_rd_data = DATA_W'(w_snap[15:0]);
    if (w_idx == IdxW'(RMON_BASE + RMON_DH)) w_rd_data = DATA_W'(w_snap[31:16]);
  end

  always_ff @(posedge Clk_reg or posedge Reset) begin
    if (Reset) begin
      r_wr_lvl <= 1'b0;
      r_cd_out <= '0;
      r_done   <= 1'b0;
      r_tout   <= 1'b0;
    end else begin
      r_wr_lvl <= w_wr_lvl;
      if (!CSB && WRB) r_cd_out <= w_rd_data;
      r_done <= (r_done & ~(w_stat_hit & CD_in[STAT_DONE])) | w_done_set;
      r_tout <= (r_tout & ~(w_stat_hit & CD_in[STAT_TOUT])) | w_tout_set;
    end
  end

  assign CD_out   = r_cd_out;
  assign rmon_irq = r_done | r_tout;

endmodule

// File: tb/tb_mac_reg_bank.sv
// Directed bench for mac_reg_bank: register access table plus hand-written RMON and
// reset sequences.
module tb_mac_reg_bank;

  localparam int unsigned NR = 48;
  localparam logic [NR*16-1:0] TbInit = (768'h001e) | (768'h0002 << (34 * 16));
  // idx4 SC, idx5 W1C, idx6 RO; everything else RW.
  localparam logic [NR*2-1:0]  TbType = (96'd2 << 8) | (96'd3 << 10) | (96'd1 << 12);

  logic              Clk_reg = 1'b0;
  logic              Reset = 1'b1;
  logic              CSB = 1'b1;
  logic              WRB = 1'b1;
  logic [7:0]        CA = '0;
  logic [15:0]       CD_in = '0;
  logic [15:0]       CD_out;
  logic [NR*16-1:0]  reg_out;
  logic [NR*16-1:0]  hw_in = '0;
  logic [NR*16-1:0]  hw_set = '0;
  logic [5:0]        CPU_rd_addr;
  logic              CPU_rd_apply;
  logic              CPU_rd_grant = 1'b0;
  logic [31:0]       CPU_rd_dout = '0;
  logic              rmon_irq;

  int total = 0;
  int bad = 0;

  mac_reg_bank #(
    .NUM_REGS     (NR),
    .DATA_W       (16),
    .ADDR_W       (8),
    .REG_INIT     (TbInit),
    .REG_TYPE     (TbType),
    .RMON_BASE    (60),
    .RMON_AW      (6),
    .RMON_TIMEOUT (8)
  ) dut (
    .Clk_reg      (Clk_reg),
    .Reset        (Reset),
    .CSB          (CSB),
    .WRB          (WRB),
    .CA           (CA),
    .CD_in        (CD_in),
    .CD_out       (CD_out),
    .reg_out      (reg_out),
    .hw_in        (hw_in),
    .hw_set       (hw_set),
    .CPU_rd_addr  (CPU_rd_addr),
    .CPU_rd_apply (CPU_rd_apply),
    .CPU_rd_grant (CPU_rd_grant),
    .CPU_rd_dout  (CPU_rd_dout),
    .rmon_irq     (rmon_irq)
  );

  always #5 Clk_reg = ~Clk_reg;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    bit          wr;
    logic [7:0]  ca;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge Clk_reg);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] ca, input logic [15:0] d);
    CSB = 1'b0; WRB = 1'b0; CA = ca; CD_in = d;
    tick();
    CSB = 1'b1; WRB = 1'b1;
    tick();
  endtask

  task automatic bus_read(input logic [7:0] ca, output logic [15:0] d);
    CSB = 1'b0; WRB = 1'b1; CA = ca;
    tick();
    d = CD_out;
    CSB = 1'b1;
  endtask

  vec_t        vecs [11];
  logic [15:0] rd;
  logic [15:0] stat_mid;
  int          n_apply;

  initial begin
    vecs[0]  = '{"rst_idx0",   1'b0, 8'h00, 16'h0000, 16'h001e};
    vecs[1]  = '{"rst_idx34",  1'b0, 8'h44, 16'h0000, 16'h0002};
    vecs[2]  = '{"rst_idx3",   1'b0, 8'h06, 16'h0000, 16'h0000};
    vecs[3]  = '{"rw_idx8",    1'b1, 8'h10, 16'ha5a5, 16'ha5a5};
    vecs[4]  = '{"ro_read",    1'b0, 8'h0c, 16'h0000, 16'habcd};
    vecs[5]  = '{"ro_wr_ign",  1'b1, 8'h0c, 16'hffff, 16'habcd};
    vecs[6]  = '{"unmap_48",   1'b0, 8'h60, 16'h0000, 16'h0000};
    vecs[7]  = '{"unmap_49",   1'b1, 8'h62, 16'h1111, 16'h0000};
    vecs[8]  = '{"rw_last",    1'b1, 8'h5e, 16'hbeef, 16'hbeef};
    vecs[9]  = '{"rw_odd_ca",  1'b1, 8'h45, 16'h7777, 16'h7777};
    vecs[10] = '{"sc_rd_back", 1'b1, 8'h08, 16'h0001, 16'h0000};

    hw_in[6*16 +: 16] = 16'habcd;
    #12 Reset = 1'b0;
    #1;
    check("rst_cd_out", CD_out, 0);
    check("rst_apply", CPU_rd_apply, 0);
    check("rst_rd_addr", CPU_rd_addr, 0);
    check("rst_irq", rmon_irq, 0);
    check("rst_reg_out0", reg_out[0 +: 16], 16'h001e);
    check("rst_reg_out34", reg_out[34*16 +: 16], 16'h0002);
    tick();

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].ca, vecs[i].wd);
      bus_read(vecs[i].ca, rd);
      check(vecs[i].name, rd, vecs[i].exp);
    end
    tick();

    // Held RW write: data changes mid-hold must not commit again.
    CSB = 1'b0; WRB = 1'b0; CA = 8'h06; CD_in = 16'h1234;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("hold_rw", reg_out[3*16 +: 16], 16'h1234);
      if (c == 1) CD_in = 16'h5678;
    end
    CSB = 1'b1; WRB = 1'b1;
    tick();

    // Held SC write: visible for exactly one cycle.
    CSB = 1'b0; WRB = 1'b0; CA = 8'h08; CD_in = 16'h0001;
    tick();
    check("sc_cycle1", reg_out[4*16 +: 16], 16'h0001);
    tick();
    check("sc_cycle2", reg_out[4*16 +: 16], 16'h0000);
    tick();
    check("sc_cycle3", reg_out[4*16 +: 16], 16'h0000);
    CSB = 1'b1; WRB = 1'b1;
    tick();

    // W1C: set pulse, clear racing a set, plain clear.
    hw_set[5*16 + 2] = 1'b1;
    tick();
    hw_set = '0;
    bus_read(8'h0a, rd);
    check("w1c_set", rd, 16'h0004);
    CSB = 1'b0; WRB = 1'b0; CA = 8'h0a; CD_in = 16'h0004; hw_set[5*16 + 2] = 1'b1;
    tick();
    CSB = 1'b1; WRB = 1'b1; hw_set = '0;
    tick();
    check("w1c_set_wins", reg_out[5*16 +: 16], 16'h0004);
    bus_write(8'h0a, 16'h0004);
    check("w1c_clear", reg_out[5*16 +: 16], 16'h0000);

    // RMON read with grant in the fourth request cycle.
    CSB = 1'b0; WRB = 1'b0; CA = 8'h78; CD_in = 16'd17;
    tick();
    CSB = 1'b1; WRB = 1'b1;
    check("rmon_addr", CPU_rd_addr, 17);
    n_apply = 0;
    for (int c = 0; c < 10; c++) begin
      if (CPU_rd_apply) n_apply++;
      CPU_rd_grant = CPU_rd_apply && (n_apply == 4);
      CPU_rd_dout  = CPU_rd_grant ? 32'hdead_beef : 32'h0;
      tick();
    end
    CPU_rd_grant = 1'b0;
    check("rmon_apply_cycles", n_apply, 4);
    check("rmon_irq_done", rmon_irq, 1);
    bus_read(8'h7a, rd);
    check("rmon_stat_done", rd, 16'h0002);
    bus_read(8'h7c, rd);
    check("rmon_dl", rd, 16'hbeef);
    bus_read(8'h7e, rd);
    check("rmon_dh", rd, 16'hdead);
    bus_write(8'h7a, 16'h0002);
    check("rmon_irq_clr", rmon_irq, 0);

    // RMON timeout, with a CTRL write and a STAT read while busy.
    CPU_rd_dout = 32'h1111_2222;
    CSB = 1'b0; WRB = 1'b0; CA = 8'h78; CD_in = 16'd5;
    tick();
    CSB = 1'b1; WRB = 1'b1;
    n_apply = 0;
    stat_mid = '0;
    for (int c = 0; c < 20; c++) begin
      if (CPU_rd_apply) n_apply++;
      case (c)
        2: begin CSB = 1'b0; WRB = 1'b0; CA = 8'h78; CD_in = 16'd9; end
        3: begin CSB = 1'b1; WRB = 1'b1; end
        4: begin CSB = 1'b0; WRB = 1'b1; CA = 8'h7a; end
        5: begin stat_mid = CD_out; CSB = 1'b1; end
        default: ;
      endcase
      tick();
    end
    check("tout_apply_cycles", n_apply, 8);
    check("tout_stat_busy", stat_mid, 16'h0001);
    check("tout_addr_kept", CPU_rd_addr, 5);
    check("tout_irq", rmon_irq, 1);
    bus_read(8'h7a, rd);
    check("tout_stat", rd, 16'h0004);
    bus_read(8'h78, rd);
    check("tout_ctrl_rb", rd, 16'd5);
    bus_read(8'h7c, rd);
    check("tout_dl_kept", rd, 16'hbeef);
    bus_read(8'h7e, rd);
    check("tout_dh_kept", rd, 16'hdead);

    // Reset in the middle of a request; TOUT is still set going in.
    CSB = 1'b0; WRB = 1'b0; CA = 8'h78; CD_in = 16'd3;
    tick();
    CSB = 1'b1; WRB = 1'b1;
    tick();
    check("mid_apply_pre", CPU_rd_apply, 1);
    #2 Reset = 1'b1;
    #1;
    check("mid_apply_async", CPU_rd_apply, 0);
    CPU_rd_grant = 1'b1; CPU_rd_dout = 32'hcafe_f00d;
    tick();
    tick();
    CPU_rd_grant = 1'b0;
    #2 Reset = 1'b0;
    tick();
    check("mid_irq", rmon_irq, 0);
    bus_read(8'h7a, rd);
    check("mid_stat", rd, 16'h0000);
    bus_read(8'h7c, rd);
    check("mid_dl", rd, 16'h0000);
    check("mid_rst_reg0", reg_out[0 +: 16], 16'h001e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
